// File: rtl/burst_mem_model_pkg.sv
// Shared definitions for the burst memory model.
//   state_t     : controller state encoding (IDLE, WAIT, XFER, DRAIN)
//   block_size  : words per block from the block-offset width
//   cnt_width   : minimum counter width able to hold a given maximum value
//   MIN_/MAX_LATENCY : legal range of the access latency parameter
package burst_mem_model_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 255;

  function automatic int block_size(input int offset_width);
    return 1 << offset_width;
  endfunction

  // Width of a counter that must reach max_value; never narrower than 1 bit.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/burst_mem_model_bram.sv
// Single-port synchronous RAM with a one-cycle registered read.
//   clk  : clock, rising edge
//   we   : write enable for addr/din
//   addr : word address
//   din  : write data
//   dout : read data for the address presented in the previous cycle
//          (read-before-write when we is high)
module burst_mem_model_bram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset port so it maps onto block RAM; its contents
  // survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/burst_mem_model.sv
// Slow main-memory model that moves whole blocks behind a cache.
//   clk, rstn  : clock (rising edge), asynchronous active-low reset
//   req_valid  : request present; must be held until req_ready
//   req_ready  : high only while idle; accept = req_valid && req_ready
//   req_we     : 1 = block write, 0 = block read (sampled at accept)
//   req_addr   : word address; upper bits = block, low bits = start word
//   req_wdata  : block write data, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rvalid     : rdata holds a read word
//   rdata      : read word
//   roffset    : block offset of the current rdata word (holds when idle)
//   rlast      : final read word of the block
//   done       : one-cycle pulse when a block write completes
//   busy       : inverse of req_ready
// After accept the controller waits LATENCY cycles, then performs one array
// access per cycle for a whole block, optionally starting at the requested
// word and wrapping, then spends one DRAIN cycle before accepting again.
module burst_mem_model
  import burst_mem_model_pkg::*;
#(
  parameter int    DATA_WIDTH         = 32,
  parameter int    ADDR_WIDTH         = 10,
  parameter int    BLOCK_OFFSET_WIDTH = 3,
  parameter int    LATENCY            = 16,
  parameter int    WRAP_FIRST         = 1,
  parameter string INIT_FILE          = ""
) (
  input  logic                                                  clk,
  input  logic                                                  rstn,
  input  logic                                                  req_valid,
  output logic                                                  req_ready,
  input  logic                                                  req_we,
  input  logic [ADDR_WIDTH-1:0]                                 req_addr,
  input  logic [block_size(BLOCK_OFFSET_WIDTH)*DATA_WIDTH-1:0]  req_wdata,
  output logic                                                  rvalid,
  output logic [DATA_WIDTH-1:0]                                 rdata,
  output logic [BLOCK_OFFSET_WIDTH-1:0]                         roffset,
  output logic                                                  rlast,
  output logic                                                  done,
  output logic                                                  busy
);

  localparam int BLOCK_SIZE = block_size(BLOCK_OFFSET_WIDTH);
  localparam int BLK_W      = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;
  localparam int LAT_W      = cnt_width(LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  if (LATENCY < MIN_LATENCY || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("burst_mem_model: LATENCY must be within 1..255");
  end
  if (BLK_W < 1) begin : g_bad_addr
    $error("burst_mem_model: ADDR_WIDTH must exceed BLOCK_OFFSET_WIDTH");
  end

  state_t                            state_q, state_d;
  logic [LAT_W-1:0]                  lat_cnt_q;
  logic [BLOCK_OFFSET_WIDTH-1:0]     beat_q;
  logic                              we_q;
  logic [BLK_W-1:0]                  blk_q;
  logic [BLOCK_OFFSET_WIDTH-1:0]     start_q;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0]  wdata_q;

  logic                              accept;
  logic                              last_beat;
  logic                              xfer_rd;
  logic [BLOCK_OFFSET_WIDTH-1:0]     beat_off;
  logic                              mem_we;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_din;

  assign accept    = req_valid && (state_q == IDLE);
  assign last_beat = (beat_q == {BLOCK_OFFSET_WIDTH{1'b1}});
  assign xfer_rd   = (state_q == XFER) && !we_q;

  // Offset arithmetic is exactly BLOCK_OFFSET_WIDTH wide so it wraps inside
  // the block without any explicit modulo.
  assign beat_off = start_q + beat_q;
  assign mem_we   = (state_q == XFER) && we_q;
  assign mem_addr = {blk_q, beat_off};
  assign mem_din  = wdata_q[beat_off*DATA_WIDTH +: DATA_WIDTH];

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign done      = (state_q == DRAIN) && we_q;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (lat_cnt_q == '0) state_d = XFER;
      XFER:    if (last_beat) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            lat_cnt_q <= LAT_LOAD;
            beat_q    <= '0;
            we_q      <= req_we;
          end
        end
        WAIT: begin
          if (lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - 1'b1;
        end
        XFER: begin
          beat_q <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Request payload is only consumed after an accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      blk_q   <= req_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
      start_q <= (WRAP_FIRST != 0) ? req_addr[BLOCK_OFFSET_WIDTH-1:0] : '0;
      wdata_q <= req_wdata;
    end
  end

  // Read tags are registered once so they line up with the array's
  // registered dout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      roffset <= '0;
    end else begin
      rvalid <= xfer_rd;
      rlast  <= xfer_rd && last_beat;
      if (xfer_rd) roffset <= beat_off;
    end
  end

  burst_mem_model_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_bram (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_din),
    .dout (rdata)
  );

endmodule
